// File: rtl/conway_cell.sv
// conway_cell
// -----------------------------------------------------------------------------
// Single-cell rule engine for a Game of Life array. Given the cell's current
// state and its 3-bit live-neighbour count, produces the next-generation state
// combinationally and as a registered copy. The birth/survive rule is held in
// two runtime-writable 8-bit masks that reset to standard Life (B3/S23).
//
// Parameters
//   BIRTH_DEFAULT   birth mask loaded at reset (bit k: dead cell with count k is born)
//   SURVIVE_DEFAULT survive mask loaded at reset (bit k: live cell with count k survives)
//
// Ports
//   clk          in   1  clock, rising edge
//   rstn         in   1  synchronous active-low reset
//   enable       in   1  generation-advance strobe for the registered outputs
//   state_in     in   1  current cell state (1 = alive)
//   nsum         in   3  live-neighbour count modulo 8
//   rule_we      in   1  rule write strobe
//   birth_in     in   8  new birth mask, taken when rule_we=1
//   survive_in   in   8  new survive mask, taken when rule_we=1
//   next_state   out  1  combinational next state
//   next_state_q out  1  registered next state
//   born_q       out  1  one-cycle pulse: last enabled step was 0->1
//   died_q       out  1  one-cycle pulse: last enabled step was 1->0
//   birth_mask   out  8  current birth rule register
//   survive_mask out  8  current survive rule register
//
// Handshake: none. enable and rule_we are plain single-edge strobes; each edge
// with the strobe high performs one action, and either may be held high
// continuously.
// -----------------------------------------------------------------------------
module conway_cell #(
  parameter logic [7:0] BIRTH_DEFAULT   = 8'b0000_1000,
  parameter logic [7:0] SURVIVE_DEFAULT = 8'b0000_1100
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       state_in,
  input  logic [2:0] nsum,
  input  logic       rule_we,
  input  logic [7:0] birth_in,
  input  logic [7:0] survive_in,
  output logic       next_state,
  output logic       next_state_q,
  output logic       born_q,
  output logic       died_q,
  output logic [7:0] birth_mask,
  output logic [7:0] survive_mask
);

  // Power-up values match the reset values.
  logic [7:0] birth_r   = BIRTH_DEFAULT;
  logic [7:0] survive_r = SURVIVE_DEFAULT;
  logic       nsq_r     = 1'b0;
  logic       born_r    = 1'b0;
  logic       died_r    = 1'b0;

  // A true count of 8 aliases to 0 and is treated exactly as 0; under Life
  // rules both are lethal, so no overflow indication is needed.
  logic rule_out;
  always_comb begin
    rule_out = 1'b0;
    if (state_in) rule_out = survive_r[nsum];
    else          rule_out = birth_r[nsum];
  end

  // Rule registers. A write on the same edge as an enabled step does not
  // affect that step: the registered path below reads the pre-edge masks.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      birth_r   <= BIRTH_DEFAULT;
      survive_r <= SURVIVE_DEFAULT;
    end else if (rule_we) begin
      birth_r   <= birth_in;
      survive_r <= survive_in;
    end
  end

  // Registered path. born/died are cleared on any non-enabled edge so each
  // enabled step produces at most a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      nsq_r  <= 1'b0;
      born_r <= 1'b0;
      died_r <= 1'b0;
    end else if (enable) begin
      nsq_r  <= rule_out;
      born_r <= ~state_in & rule_out;
      died_r <= state_in & ~rule_out;
    end else begin
      born_r <= 1'b0;
      died_r <= 1'b0;
    end
  end

  assign next_state   = rule_out;
  assign next_state_q = nsq_r;
  assign born_q       = born_r;
  assign died_q       = died_r;
  assign birth_mask   = birth_r;
  assign survive_mask = survive_r;

endmodule

// File: tb/tb_conway_cell.sv
module tb_conway_cell;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b0;
  logic       state_in = 1'b0;
  logic [2:0] nsum = 3'd0;
  logic       rule_we = 1'b0;
  logic [7:0] birth_in = 8'h00;
  logic [7:0] survive_in = 8'h00;
  logic       next_state;
  logic       next_state_q;
  logic       born_q;
  logic       died_q;
  logic [7:0] birth_mask;
  logic [7:0] survive_mask;

  always #5 clk = ~clk;

  conway_cell dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .state_in     (state_in),
    .nsum         (nsum),
    .rule_we      (rule_we),
    .birth_in     (birth_in),
    .survive_in   (survive_in),
    .next_state   (next_state),
    .next_state_q (next_state_q),
    .born_q       (born_q),
    .died_q       (died_q),
    .birth_mask   (birth_mask),
    .survive_mask (survive_mask)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Rule as a set of counts: the cell is alive next generation when its
  // neighbour count is a member of the birth set (dead) or survive set (alive).
  function automatic logic life_rule(input logic st, input logic [2:0] n,
                                     input logic [7:0] b, input logic [7:0] s);
    int         counts[$];
    logic [7:0] m;
    m = st ? s : b;
    for (int k = 0; k < 8; k++)
      if (m[k]) counts.push_back(k);
    foreach (counts[i])
      if (counts[i] == int'(n)) return 1'b1;
    return 1'b0;
  endfunction

  logic [7:0] m_birth   = 8'h08;
  logic [7:0] m_survive = 8'h0C;
  logic       m_nsq = 1'b0, m_born = 1'b0, m_died = 1'b0;

  always @(posedge clk) begin
    logic nxt;
    if (!rstn) begin
      m_birth = 8'h08; m_survive = 8'h0C;
      m_nsq = 1'b0; m_born = 1'b0; m_died = 1'b0;
    end else begin
      nxt = life_rule(state_in, nsum, m_birth, m_survive);
      if (enable) begin
        m_born = (state_in == 1'b0) && (nxt == 1'b1);
        m_died = (state_in == 1'b1) && (nxt == 1'b0);
        m_nsq  = nxt;
      end else begin
        m_born = 1'b0; m_died = 1'b0;
      end
      if (rule_we) begin
        m_birth = birth_in; m_survive = survive_in;
      end
    end
  end

  // ---------------- scoreboard compare (every cycle, on the falling edge) ----
  always @(negedge clk) begin
    check("m_next_state", {7'd0, next_state},
          {7'd0, life_rule(state_in, nsum, m_birth, m_survive)});
    check("m_next_state_q", {7'd0, next_state_q}, {7'd0, m_nsq});
    check("m_born_q", {7'd0, born_q}, {7'd0, m_born});
    check("m_died_q", {7'd0, died_q}, {7'd0, m_died});
    check("m_birth_mask", birth_mask, m_birth);
    check("m_survive_mask", survive_mask, m_survive);
  end

  // ---------------- driver ----------------
  // Drive just after a falling edge, then return at the next falling edge,
  // so one rising edge has consumed the vector and outputs are settled.
  task automatic cycle(input logic r, input logic st, input logic [2:0] n, input logic en,
                       input logic we, input logic [7:0] b, input logic [7:0] s);
    #1;
    rstn = r; state_in = st; nsum = n; enable = en;
    rule_we = we; birth_in = b; survive_in = s;
    @(negedge clk);
  endtask

  typedef struct {
    logic st; logic [2:0] n; logic en; logic we; logic [7:0] b; logic [7:0] s;
  } vec_t;

  initial begin
    logic [7:0] alive_tbl;
    logic [7:0] dead_tbl;
    vec_t vecs[10];
    alive_tbl = 8'b0000_1100;
    dead_tbl  = 8'b0000_1000;

    // Reset
    @(negedge clk);
    cycle(0, 0, 3'd0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 3'd0, 0, 0, 8'h00, 8'h00);
    check("rst_nsq", {7'd0, next_state_q}, 8'd0);
    check("rst_born", {7'd0, born_q}, 8'd0);
    check("rst_died", {7'd0, died_q}, 8'd0);
    check("rst_birth", birth_mask, 8'h08);
    check("rst_survive", survive_mask, 8'h0C);

    // Default rule sweep
    for (int s = 0; s < 2; s++)
      for (int n = 0; n < 8; n++) begin
        cycle(1, s[0], n[2:0], 0, 0, 8'h00, 8'h00);
        check($sformatf("sweep_s%0d_n%0d", s, n), {7'd0, next_state},
              {7'd0, (s == 1) ? alive_tbl[n] : dead_tbl[n]});
      end

    // Registered path and pulses
    cycle(1, 0, 3'd3, 1, 0, 8'h00, 8'h00);
    check("birth_nsq", {7'd0, next_state_q}, 8'd1);
    check("birth_born", {7'd0, born_q}, 8'd1);
    check("birth_died", {7'd0, died_q}, 8'd0);
    cycle(1, 0, 3'd3, 0, 0, 8'h00, 8'h00);
    check("hold_born", {7'd0, born_q}, 8'd0);
    check("hold_nsq", {7'd0, next_state_q}, 8'd1);
    cycle(1, 1, 3'd4, 1, 0, 8'h00, 8'h00);
    check("death_nsq", {7'd0, next_state_q}, 8'd0);
    check("death_died", {7'd0, died_q}, 8'd1);
    check("death_born", {7'd0, born_q}, 8'd0);

    // HighLife B36/S23
    cycle(1, 0, 3'd0, 0, 1, 8'h48, 8'h0C);
    check("wr_birth", birth_mask, 8'h48);
    check("wr_survive", survive_mask, 8'h0C);
    cycle(1, 0, 3'd6, 0, 0, 8'h00, 8'h00);
    check("highlife_b6", {7'd0, next_state}, 8'd1);

    // Simultaneous write and enable: old rule applies on that edge
    cycle(1, 0, 3'd3, 1, 1, 8'h00, 8'h0C);
    check("simul_nsq", {7'd0, next_state_q}, 8'd1);
    check("simul_born", {7'd0, born_q}, 8'd1);
    cycle(1, 0, 3'd3, 0, 0, 8'h00, 8'h00);
    check("simul_after", {7'd0, next_state}, 8'd0);

    // Reset mid-operation with enable and rule_we also high
    cycle(0, 0, 3'd3, 1, 1, 8'hFF, 8'hFF);
    check("mid_rst_nsq", {7'd0, next_state_q}, 8'd0);
    check("mid_rst_born", {7'd0, born_q}, 8'd0);
    check("mid_rst_died", {7'd0, died_q}, 8'd0);
    check("mid_rst_birth", birth_mask, 8'h08);
    check("mid_rst_survive", survive_mask, 8'h0C);
    check("mid_rst_comb", {7'd0, next_state}, 8'd1);

    // Mixed directed run, checked by the scoreboard each cycle
    vecs[0] = '{1, 3'd2, 1, 0, 8'h00, 8'h00};
    vecs[1] = '{1, 3'd0, 1, 0, 8'h00, 8'h00};
    vecs[2] = '{0, 3'd3, 1, 1, 8'h03, 8'hF0};
    vecs[3] = '{0, 3'd1, 1, 0, 8'h00, 8'h00};
    vecs[4] = '{1, 3'd5, 1, 0, 8'h00, 8'h00};
    vecs[5] = '{1, 3'd3, 1, 0, 8'h00, 8'h00};
    vecs[6] = '{0, 3'd0, 0, 0, 8'h00, 8'h00};
    vecs[7] = '{0, 3'd0, 1, 0, 8'h00, 8'h00};
    vecs[8] = '{1, 3'd7, 1, 1, 8'h08, 8'h0C};
    vecs[9] = '{1, 3'd7, 1, 0, 8'h00, 8'h00};
    foreach (vecs[i])
      cycle(1, vecs[i].st, vecs[i].n, vecs[i].en, vecs[i].we, vecs[i].b, vecs[i].s);
    cycle(1, 0, 3'd0, 0, 0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conway_cell.md
# conway_cell

Single-cell rule engine for the Conway Game of Life array. It takes a cell's current state and its 3-bit live-neighbour count and produces the cell's next-generation state. The result is available combinationally, for the shift-register stripe that feeds it, and as a registered copy. The birth/survive rule is runtime-programmable and resets to standard Life (B3/S23).

## Interface
Parameters:
- BIRTH_DEFAULT, 8'b0000_1000, birth mask loaded at reset; bit k set means a dead cell with count k becomes alive.
- SURVIVE_DEFAULT, 8'b0000_1100, survive mask loaded at reset; bit k set means a live cell with count k stays alive.

Ports:
- clk, in, 1, clock; all registers update on rising edge.
- rstn, in, 1, reset, synchronous, active-low.
- enable, in, 1, generation-advance strobe for registered outputs.
- state_in, in, 1, current cell state (1 = alive).
- nsum, in, 3, live-neighbour count, modulo 8.
- rule_we, in, 1, rule write strobe.
- birth_in, in, 8, new birth mask, sampled when rule_we=1.
- survive_in, in, 8, new survive mask, sampled when rule_we=1.
- next_state, out, 1, combinational next state.
- next_state_q, out, 1, registered next state.
- born_q, out, 1, registered pulse: the last enabled step was a 0→1 transition.
- died_q, out, 1, registered pulse: the last enabled step was a 1→0 transition.
- birth_mask, out, 8, current birth rule register.
- survive_mask, out, 8, current survive rule register.

## Operation
- Combinational rule:
  - next_state = state_in ? survive_mask[nsum] : birth_mask[nsum].
  - Default rule: alive with nsum ∈ {2,3} gives 1; dead with nsum = 3 gives 1; every other case gives 0.
- Count aliasing: nsum is 3 bits. A true count of 8 arrives as 0 and is treated exactly as 0, so under default rules it gives 0. This matches Life, because 8 neighbours kills a cell. No overflow flag is provided.
- next_state has no dependence on enable, rule_we in the same cycle, or clk. It depends only on state_in, nsum and the current mask registers.
- Registered path, on a clock edge with rstn=1 and enable=1:
  - next_state_q ← next_state.
  - born_q ← ~state_in & next_state.
  - died_q ← state_in & ~next_state.
- With enable=0: next_state_q holds its value; born_q and died_q clear to 0, so each is a single-cycle pulse per enabled step.
- Rule write: on an edge with rstn=1 and rule_we=1, birth_mask ← birth_in and survive_mask ← survive_in.
  - The write is independent of enable.
  - If rule_we and enable are both 1 on the same edge, the registered path uses the old masks. The new masks apply from the next cycle.
- Reset (rstn=0 at an edge) takes priority over enable and rule_we:
  - next_state_q = 0, born_q = 0, died_q = 0.
  - birth_mask = BIRTH_DEFAULT, survive_mask = SURVIVE_DEFAULT.
  - During reset, next_state continues to evaluate combinationally against the mask registers.
- Power-up initial values equal the reset values.

## Timing
- next_state: zero-cycle latency.
- next_state_q, born_q, died_q: 1-cycle latency from an enabled edge.
- Mask updates are visible on birth_mask/survive_mask and in next_state one cycle after the rule_we edge.
- Reset asserted mid-run clears the registered outputs and restores the default rule at that edge. Operation resumes on the first edge with rstn=1.
- There is no handshake: enable is a plain strobe and may be held high continuously.

## Test plan
- Default rule sweep: for state_in ∈ {0,1} and nsum 0..7, check next_state.
  - state_in=1: next_state=1 only at nsum 2 and 3.
  - state_in=0: next_state=1 only at nsum 3.
  - nsum=0 standing in for a true count of 8 gives 0.
- Registered path and pulses:
  - state_in=0, nsum=3, enable=1 → next cycle: next_state_q=1, born_q=1, died_q=0.
  - Then enable=0 → born_q=0 and next_state_q holds 1.
  - state_in=1, nsum=4, enable=1 → next_state_q=0, died_q=1.
- Rule reprogramming: write birth_in=8'h48, survive_in=8'h0C (HighLife B36/S23).
  - Next cycle: state_in=0, nsum=6 → next_state=1; masks read back 8'h48/8'h0C.
- Simultaneous write and enable: rule_we=1 with birth_in=8'h00, enable=1, state_in=0, nsum=3.
  - next_state_q=1, because the old rule applies on that edge.
  - On the following cycle next_state=0 for the same inputs.
- Reset mid-operation: with next_state_q=1 and custom masks loaded, drive rstn=0 for one edge.
  - Outputs: next_state_q=0, born_q=died_q=0, birth_mask=8'h08, survive_mask=8'h0C.
  - rstn=0 together with enable=1 still yields reset values.
